// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_unit
//  Purpose  : Instruction prefetcher. Issues sequential 4-byte fetch requests
//             to an in-order memory port, queues returned instruction words
//             with their PCs and presents them to the decoder. Requests are
//             credit-limited so the queue can never overflow. A redirect
//             flushes the queue, restarts fetch at a new PC and drops every
//             response still in flight.
//  Macro    : PREFETCH_BYPASS_EN - when defined, a response arriving while the
//             queue is empty is presented to the decoder in the same cycle.
//             When undefined, inst_valid depends on registered state only.
//  Ports    : clk, reset (sync, active-high)
//             redirect, redirect_pc      - flush and refetch from redirect_pc
//             halt                       - stop issuing new memory requests
//             mem_req_valid/ready/addr   - fetch request channel
//             mem_rsp_valid/data         - in-order response channel
//             inst_valid/ready/data/pc   - decoder channel (queue head)
//  Revision : 1.0 - initial release
// ============================================================================
module prefetch_unit #(
    parameter int             XLEN     = 64,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 'h2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_q_data [DEPTH];
    logic [XLEN-1:0]    r_q_pc   [DEPTH];

    logic [c_CNT_W:0]   w_credit_sum;
    logic               w_req_hs;
    logic               w_rsp_keep;
    logic               w_q_empty;
    logic               w_bypass;
    logic               w_pop;
    logic               w_enq;
    logic [c_CNT_W-1:0] w_outstanding_nxt;

    // Queued words plus in-flight requests bound the future queue occupancy,
    // so keeping their sum below DEPTH guarantees room for every response.
    assign w_credit_sum  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign mem_req_valid = !reset && !halt && (w_credit_sum < (c_CNT_W + 1)'(DEPTH));
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_hs      = mem_req_valid && mem_req_ready;

    // A response is dropped if it belongs to a flushed stream: either the
    // redirect happens this cycle or older discards are still pending.
    assign w_rsp_keep    = mem_rsp_valid && !redirect && (r_discard == '0);
    assign w_q_empty     = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass      = w_q_empty && w_rsp_keep;
`else
    assign w_bypass      = 1'b0;
`endif

    assign inst_valid    = !reset && (!w_q_empty || w_bypass);
    assign inst_data     = w_bypass ? mem_rsp_data : r_q_data[r_rd_ptr];
    assign inst_pc       = w_bypass ? r_rsp_pc     : r_q_pc[r_rd_ptr];

    assign w_pop         = inst_valid && inst_ready && !w_q_empty;
    // A bypassed word that the decoder takes immediately never enters the queue.
    assign w_enq         = w_rsp_keep && !(w_bypass && inst_ready);

    assign w_outstanding_nxt = r_outstanding + c_CNT_W'(w_req_hs) - c_CNT_W'(mem_rsp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect) begin
                // Every request still unanswered after this cycle belongs to
                // the old stream, including one accepted right now.
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_discard  <= w_outstanding_nxt;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_hs) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp_keep) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                end
                if (mem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - c_CNT_W'(1);
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_pop);
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_q_data[r_wr_ptr] <= mem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule
`default_nettype wire
